// File: rtl/pll_lock_seq.sv
// PLL lock sequencer: pulses the PLL reset, waits for a stable synchronized lock, then releases sys_rst.
// Optional build macro LOCK_LOSS_FILTER_EN: in RUN, lock loss needs 4 consecutive low cycles of lock_s.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// PLL_RST   | PLL held in reset for PLL_RST_CYC cycles
// WAIT_LOCK | PLL released, waiting for lock_s; times out after LOCK_TIMEOUT_CYC
// STABLE    | lock seen, must hold for LOCK_STABLE_CYC consecutive cycles
// RUN       | locked, downstream logic out of reset
// FAULT     | MAX_RETRY consecutive timeouts; terminal until rst
module pll_lock_seq #(
    parameter int PLL_RST_CYC      = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 270000,
    parameter int MAX_RETRY        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       locked,
    output logic       fault,
    output logic [7:0] relock_cnt
);

    localparam int RST_W   = $clog2(PLL_RST_CYC + 1);
    localparam int STB_W   = $clog2(LOCK_STABLE_CYC + 1);
    localparam int TO_W    = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(PLL_RST_CYC - 1);
    localparam logic [STB_W-1:0]   STB_LAST  = STB_W'(LOCK_STABLE_CYC - 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    if (PLL_RST_CYC < 1 || LOCK_STABLE_CYC < 1 || LOCK_TIMEOUT_CYC < 1 || MAX_RETRY < 1) begin : g_param_check
        $error("pll_lock_seq: all cycle/retry parameters must be >= 1");
    end

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t             state;
    logic               lock_meta;
    logic               lock_s;
    logic [RST_W-1:0]   rst_cnt;
    logic [STB_W-1:0]   stb_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [RETRY_W-1:0] retry;
    logic [RETRY_W-1:0] retry_inc;
    logic [3:0]         outs;
    logic               lock_loss;

    // {pll_reset, sys_rst, locked, fault} for the state being entered
    function automatic logic [3:0] dec(input state_t s);
        case (s)
            PLL_RST:   dec = 4'b1100;
            WAIT_LOCK: dec = 4'b0100;
            STABLE:    dec = 4'b0100;
            RUN:       dec = 4'b0010;
            FAULT:     dec = 4'b0101;
            default:   dec = 4'b1100;
        endcase
    endfunction

    assign {pll_reset, sys_rst, locked, fault} = outs;
    assign retry_inc = retry + 1'b1;

    // pll_lock is asynchronous; nothing but this synchronizer looks at it
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

`ifdef LOCK_LOSS_FILTER_EN
    logic [1:0] low_cnt;

    assign lock_loss = !lock_s && (low_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst || state != RUN || lock_s) begin
            low_cnt <= 2'd0;
        end else if (low_cnt != 2'd3) begin
            low_cnt <= low_cnt + 2'd1;
        end
    end
`else
    assign lock_loss = !lock_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PLL_RST;
            rst_cnt    <= '0;
            stb_cnt    <= '0;
            to_cnt     <= '0;
            retry      <= '0;
            relock_cnt <= 8'd0;
            outs       <= dec(PLL_RST);
        end else begin
            case (state)
                PLL_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        state  <= WAIT_LOCK;
                        to_cnt <= '0;
                        outs   <= dec(WAIT_LOCK);
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // a lock arriving on the timeout cycle takes priority
                    if (lock_s) begin
                        state   <= STABLE;
                        stb_cnt <= '0;
                        outs    <= dec(STABLE);
                    end else if (to_cnt == TO_LAST) begin
                        retry <= retry_inc;
                        if (retry_inc == RETRY_MAX) begin
                            state <= FAULT;
                            outs  <= dec(FAULT);
                        end else begin
                            state   <= PLL_RST;
                            rst_cnt <= '0;
                            outs    <= dec(PLL_RST);
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state  <= WAIT_LOCK;
                        to_cnt <= '0;
                        outs   <= dec(WAIT_LOCK);
                    end else if (stb_cnt == STB_LAST) begin
                        state <= RUN;
                        retry <= '0;
                        outs  <= dec(RUN);
                    end else begin
                        stb_cnt <= stb_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (lock_loss) begin
                        state   <= PLL_RST;
                        rst_cnt <= '0;
                        outs    <= dec(PLL_RST);
                        if (relock_cnt != 8'hFF) begin
                            relock_cnt <= relock_cnt + 8'd1;
                        end
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state   <= PLL_RST;
                    rst_cnt <= '0;
                    outs    <= dec(PLL_RST);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_seq.sv
// Testbench for pll_lock_seq: scoreboard of expected output changes from a phase/elapsed-time model.
// Honours LOCK_LOSS_FILTER_EN the same way the design does.
module tb_pll_lock_seq;

    localparam int RST_CYC = 4;
    localparam int STB_CYC = 8;
    localparam int TO_CYC  = 32;
    localparam int MAXR    = 2;
`ifdef LOCK_LOSS_FILTER_EN
    localparam int FILT = 4;
`else
    localparam int FILT = 1;
`endif

    localparam int P_PRST  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_STAB  = 2;
    localparam int P_RUN   = 3;
    localparam int P_FAULT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       pll_reset;
    logic       sys_rst;
    logic       locked;
    logic       fault;
    logic [7:0] relock_cnt;

    pll_lock_seq #(
        .PLL_RST_CYC     (RST_CYC),
        .LOCK_STABLE_CYC (STB_CYC),
        .LOCK_TIMEOUT_CYC(TO_CYC),
        .MAX_RETRY       (MAXR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .sys_rst   (sys_rst),
        .locked    (locked),
        .fault     (fault),
        .relock_cnt(relock_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [11:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   edge_n = 0;
    int   mon_n  = 0;

    // reference model: phase plus time spent in it, a 2-deep delay line for the synchronizer
    int          m_phase, m_age, m_retry, m_relock, m_low;
    bit          dly0, dly1;
    logic [11:0] m_prev;
    bit          m_first = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [11:0] m_out();
        logic [3:0] f;
        case (m_phase)
            P_PRST:  f = 4'b1100;
            P_RUN:   f = 4'b0010;
            P_FAULT: f = 4'b0101;
            default: f = 4'b0100;
        endcase
        return {f, 8'(m_relock)};
    endfunction

    task automatic model_edge(input bit r, input bit lk);
        bit          ls;
        logic [11:0] o;
        exp_t        e;
        if (r) begin
            m_phase = P_PRST; m_age = 0; m_retry = 0; m_relock = 0; m_low = 0;
            dly0 = 1'b0; dly1 = 1'b0;
        end else begin
            ls = dly0; dly0 = dly1; dly1 = lk;
            case (m_phase)
                P_PRST: begin
                    m_age++;
                    if (m_age == RST_CYC) begin m_phase = P_WAIT; m_age = 0; end
                end
                P_WAIT: begin
                    if (ls) begin
                        m_phase = P_STAB; m_age = 0;
                    end else begin
                        m_age++;
                        if (m_age == TO_CYC) begin
                            m_retry++;
                            m_age = 0;
                            m_phase = (m_retry == MAXR) ? P_FAULT : P_PRST;
                        end
                    end
                end
                P_STAB: begin
                    if (!ls) begin
                        m_phase = P_WAIT; m_age = 0;
                    end else begin
                        m_age++;
                        if (m_age == STB_CYC) begin m_phase = P_RUN; m_retry = 0; m_low = 0; end
                    end
                end
                P_RUN: begin
                    m_low = ls ? 0 : m_low + 1;
                    if (m_low >= FILT) begin
                        m_phase = P_PRST; m_age = 0;
                        if (m_relock < 255) m_relock++;
                    end
                end
                default: ;
            endcase
        end
        o = m_out();
        if (m_first || o !== m_prev) begin
            e.cyc = edge_n;
            e.val = o;
            exp_q.push_back(e);
        end
        m_prev  = o;
        m_first = 1'b0;
    endtask

    task automatic step(input bit r, input bit lk);
        @(negedge clk);
        rst = r;
        pll_lock = lk;
        @(posedge clk);
        edge_n++;
        model_edge(r, lk);
        #1;
    endtask

    task automatic hold(input bit lk, input int n);
        for (int i = 0; i < n; i++) step(1'b0, lk);
    endtask

    task automatic wait_model(input int ph, input int age, input int retry, input int budget);
        int b;
        b = budget;
        while (!(m_phase == ph && m_age == age && m_retry == retry) && b > 0) begin
            step(1'b0, 1'b0);
            b--;
        end
        if (b == 0) begin
            total++; bad++;
            $display("FAIL wait_model: phase=%0d age=%0d retry=%0d not reached", ph, age, retry);
        end
    endtask

    // monitor: every change of the output tuple must match the next queued expectation
    logic [11:0] mon_prev;
    bit          mon_first = 1'b1;
    always @(negedge clk) begin
        logic [11:0] cur;
        exp_t        e;
        mon_n++;
        cur = {pll_reset, sys_rst, locked, fault, relock_cnt};
        if (mon_first || cur !== mon_prev) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_change: actual=%0h required=no change at cycle %0d", cur, mon_n);
            end else begin
                e = exp_q.pop_front();
                chk("out_tuple", 32'(cur), 32'(e.val));
                chk("out_cycle", mon_n, e.cyc);
            end
        end
        mon_prev  = cur;
        mon_first = 1'b0;
    end

    initial begin
        rst = 1'b1;
        pll_lock = 1'b0;
        @(posedge clk);
        edge_n = 1;
        model_edge(1'b1, 1'b0);
        #1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("reset_pll_reset", pll_reset, 1);
        chk("reset_fault", fault, 0);

        // release with lock low: pll_reset held exactly the reset window
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0);
            chk("prst_hold", pll_reset, (i < 4) ? 1 : 0);
        end
        chk("wait_sys_rst", sys_rst, 1);
        chk("wait_locked", locked, 0);

        // lock 10 cycles into WAIT_LOCK, RUN 11 cycles after the rise
        hold(1'b0, 10);
        for (int i = 1; i <= 11; i++) begin
            step(1'b0, 1'b1);
            chk("run_latency", locked, (i == 11) ? 1 : 0);
        end
        chk("run_sys_rst", sys_rst, 0);
        chk("run_relock", relock_cnt, 0);

        // two-cycle glitch in RUN
        hold(1'b1, 5);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("glitch_relock", relock_cnt, (FILT == 1) ? 1 : 0);
        chk("glitch_locked", locked, (FILT == 1) ? 0 : 1);
        hold(1'b1, 25);

        // no lock ever: two timeouts then FAULT
        step(1'b1, 1'b0);
        hold(1'b0, 80);
        chk("fault_fault", fault, 1);
        chk("fault_pll_reset", pll_reset, 0);
        chk("fault_sys_rst", sys_rst, 1);
        step(1'b1, 1'b0);
        chk("fault_cleared", fault, 0);
        chk("fault_rst_pll_reset", pll_reset, 1);

        // one timeout, lock arriving on the timeout cycle, STABLE drop, then final timeout
        wait_model(P_WAIT, TO_CYC - 3, 1, 200);
        hold(1'b1, 6);
        hold(1'b0, 5);
        chk("stable_drop_no_prst", pll_reset, 0);
        hold(1'b0, 40);
        chk("collision_retry_fault", fault, 1);

        // randomized lock activity with occasional resets
        step(1'b1, 1'b0);
        for (int s = 0; s < 60; s++) begin
            bit lk;
            int len;
            if ($urandom_range(0, 19) == 0) begin
                len = $urandom_range(1, 3);
                for (int k = 0; k < len; k++) step(1'b1, 1'b0);
            end else begin
                lk = 1'($urandom_range(0, 1));
                if (lk) len = $urandom_range(1, 30);
                else if ($urandom_range(0, 3) == 0) len = $urandom_range(20, 80);
                else len = $urandom_range(1, 6);
                hold(lk, len);
            end
        end

        // saturation of relock_cnt
        step(1'b1, 1'b0);
        hold(1'b1, 30);
        chk("sat_start_locked", locked, 1);
        for (int i = 0; i < 300; i++) begin
            hold(1'b0, 5);
            hold(1'b1, 20);
        end
        chk("sat_relock", relock_cnt, 255);
        chk("sat_locked", locked, 1);

        hold(1'b1, 3);
        @(negedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
